acc_sched: RTL and testbench
============================

ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 SHALL have parameter DW, default 16: sample and sum width.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters (power of two, 2..8).
REQ-003 SHALL have parameter LEN, default 7: samples per accumulation job (2..15).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, NREQ: per-requester request strobe; one-cycle pulse, latched internally.
REQ-007 SHALL have port sdi, input, NREQ*DW: per-requester sample lanes; lane i is sdi[i*DW +: DW].
REQ-008 SHALL have port grant, output, NREQ: one-hot; the lane whose sample is consumed this cycle.
REQ-009 SHALL have port busy, output, 1: high while a job is in progress.
REQ-010 SHALL have port out, output, DW: finished sum, held stable until the next result.
REQ-011 SHALL have port out_id, output, clog2(NREQ): requester index of out.
REQ-012 SHALL have port finish, output, 1: one-cycle pulse marking a new out/out_id.

Function
REQ-013 SHALL latch each req[i] pulse into pending[i]; a pending bit cleared only when its job is granted; a req[i] pulse in the same cycle as that clear re-sets pending[i].
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 IDLE: if any pending bit is set, the round-robin winner is chosen, starting from the index after last_id; next state RUN; sum cleared.
REQ-016 RUN: for exactly LEN consecutive cycles, grant is one-hot on the winner and sum <= sum + the winner's lane; the counter counts 0..LEN-1; after count LEN-1, next state DONE.
REQ-017 DONE: for one cycle, finish=1, out=final sum, out_id=winner; last_id <= winner; next state IDLE.
REQ-018 Latency: the first sample is consumed 2 cycles after the req pulse in IDLE; finish occurs LEN+1 cycles after the first grant cycle.
REQ-019 busy SHALL be high in RUN and DONE; grant SHALL be 0 outside RUN.
REQ-020 Addition SHALL be unsigned modulo 2^DW (wrap-around), except as given in REQ-025.
REQ-021 A req pulse arriving during RUN/DONE SHALL only set pending; it never pre-empts the current job.
REQ-022 Back-to-back jobs: at most one idle cycle between DONE and the next RUN.

Reset
REQ-023 On rst: state=IDLE; pending=0, grant=0, busy=0, finish=0, out=0, out_id=0, sum=0, counter=0; last_id=NREQ-1, so index 0 wins first.
REQ-024 rst asserted mid-job SHALL abort the job with no finish pulse; req pulses in the rst cycle are discarded.

Configuration
REQ-025 Macro ACC_SCHED_SAT_EN defined: addition SHALL be signed two's-complement saturating, clamping to 0x7FFF / 0x8000 for DW=16. Macro undefined: wrap-around only, with no saturation logic present.

Structure
REQ-026 A shared package acc_sched_pkg SHALL hold the state encoding (IDLE/RUN/DONE), the default DW/NREQ/LEN values and the id-width function.
REQ-027 The round-robin picker SHALL be one sub-module, rr_arb: inputs pending and last_id; outputs a one-hot winner and its index.

Verification
REQ-028 LEN=7, req=0001 pulse, lane0 = 1,2,...,7 -> finish on cycle 10 after the pulse; out=28, out_id=0; grant=0001 for exactly 7 cycles.
REQ-029 req=1111 in one cycle -> jobs served in order 0,1,2,3; 4 finish pulses; out_id sequence 0,1,2,3.
REQ-030 Lane0 held at 0xF000 for 7 samples, macro undefined -> out=0x9000 (wrap). Macro defined, lane0 = 0x7000 -> out=0x7FFF; lane0 = 0x9000 -> out=0x8000.
REQ-031 Requester 2 pulses req during its own RUN -> a second job for requester 2 runs after the other pending jobs; it is never lost.
REQ-032 rst pulsed on the 4th RUN cycle -> no finish; all outputs are 0 the next cycle; a subsequent req=0100 gives a correct fresh sum.
REQ-033 Pending 0 and 3 after last_id=0 -> requester 3 is granted before requester 0.

Source files
------------

// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: definitions shared by the accumulation scheduler and its arbiter.
// Holds the FSM state encoding, the default parameter values, the job
// counter width and the requester-index width function.
package acc_sched_pkg;

  localparam int DEF_DW   = 16;
  localparam int DEF_NREQ = 4;
  localparam int DEF_LEN  = 7;

  // LEN is at most 15, so a 4-bit sample counter is always wide enough
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of a requester index; never below one bit
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_sched_rr_arb.sv
// rr_arb: combinational round-robin picker.
// The search starts at the index after last_id and wraps around, so the
// requester served most recently has the lowest priority.
// Ports:
//   pending   - per-requester pending bits
//   last_id   - index of the requester served most recently
//   win_oh    - one-hot winner (0 when nothing is pending)
//   win_idx   - index of the winner (0 when nothing is pending)
module rr_arb
  import acc_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last_id,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // NREQ is a power of two, so IW-bit addition wraps exactly at NREQ;
  // k == NREQ lands back on last_id itself as the final candidate.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = last_id + IW'(k);
      if (!w_found && pending[w_cand]) begin
        w_found         = 1'b1;
        win_idx         = w_cand;
        win_oh[w_cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler that accumulates LEN samples from the
// granted requester's lane and reports the sum with the requester's index.
// Build option: define ACC_SCHED_SAT_EN for signed saturating accumulation;
// otherwise the sum wraps modulo 2^DW.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   req     - per-requester one-cycle request pulse (latched as pending)
//   sdi     - sample lanes, lane i = sdi[i*DW +: DW]
//   grant   - one-hot lane consumed this cycle (0 outside RUN)
//   busy    - high in RUN and DONE
//   out     - last finished sum, held until the next result
//   out_id  - requester index belonging to out
//   finish  - one-cycle pulse when out/out_id update
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting; picks round-robin winner when any pending
// S_RUN  | LEN cycles consuming the winner's lane into sum
// S_DONE | one cycle publishing sum/winner, updating last_id
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREQ = DEF_NREQ,
  parameter int LEN  = DEF_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      sdi,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [DW-1:0]           out,
  output logic [id_w(NREQ)-1:0]   out_id,
  output logic                    finish
);

  localparam int IW = id_w(NREQ);

  state_t            r_state, w_next;
  logic [NREQ-1:0]   r_pending;
  logic [IW-1:0]     r_last_id;
  logic [IW-1:0]     r_idx;
  logic [NREQ-1:0]   r_oh;
  logic [CNT_W-1:0]  r_cnt;
  logic [DW-1:0]     r_sum;

  logic              w_any;
  logic [NREQ-1:0]   w_win_oh;
  logic [IW-1:0]     w_win_idx;
  logic [NREQ-1:0]   w_clr;
  logic [DW-1:0]     w_lane;
  logic [DW-1:0]     w_sum_nxt;

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .pending (r_pending),
    .last_id (r_last_id),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx)
  );

  assign w_any  = |r_pending;
  assign w_clr  = (r_state == S_IDLE && w_any) ? w_win_oh : '0;
  assign w_lane = sdi[int'(r_idx)*DW +: DW];

`ifdef ACC_SCHED_SAT_EN
  logic [DW-1:0] w_raw;
  logic          w_ovf;
  assign w_raw = r_sum + w_lane;
  // Overflow only when both operands share a sign the result does not
  assign w_ovf = (r_sum[DW-1] == w_lane[DW-1]) && (w_raw[DW-1] != r_sum[DW-1]);
  assign w_sum_nxt = !w_ovf        ? w_raw :
                     r_sum[DW-1]   ? {1'b1, {(DW-1){1'b0}}} :
                                     {1'b0, {(DW-1){1'b1}}};
`else
  assign w_sum_nxt = r_sum + w_lane;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    grant  = '0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_RUN;
      S_RUN: begin
        grant = r_oh;
        busy  = 1'b1;
        if (r_cnt == CNT_W'(LEN-1)) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_last_id <= IW'(NREQ-1);
      r_idx     <= '0;
      r_oh      <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      out       <= '0;
      out_id    <= '0;
      finish    <= 1'b0;
    end else begin
      finish    <= 1'b0;
      // a new pulse wins over the grant clear in the same cycle
      r_pending <= (r_pending & ~w_clr) | req;
      case (r_state)
        S_IDLE: begin
          r_sum <= '0;
          r_cnt <= '0;
          if (w_any) begin
            r_idx <= w_win_idx;
            r_oh  <= w_win_oh;
          end
        end
        S_RUN: begin
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          out       <= r_sum;
          out_id    <= r_idx;
          finish    <= 1'b1;
          r_last_id <= r_idx;
          r_cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: directed scenarios plus random traffic for acc_sched, checked
// every cycle against a job-level reference model of the scheduler.
module tb_acc_sched;

  localparam int DW   = 16;
  localparam int NREQ = 4;
  localparam int LEN  = 7;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DW-1:0]   sdi = '0;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic [DW-1:0]        out;
  logic [IW-1:0]        out_id;
  logic                 finish;

  always #5 clk = ~clk;

  acc_sched #(.DW(DW), .NREQ(NREQ), .LEN(LEN)) dut (
    .clk(clk), .rst(rst), .req(req), .sdi(sdi),
    .grant(grant), .busy(busy), .out(out), .out_id(out_id), .finish(finish)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a job is LEN sample cycles followed by one wrap-up
  // cycle; the result becomes visible the cycle after the wrap-up.
  bit [NREQ-1:0] m_pend;
  int            m_last;
  int            m_job;
  int            m_pos;
  bit            m_active;
  bit            m_wrap;
  longint        m_sum;
  logic [DW-1:0] m_out;
  int            m_oid;
  bit            m_fin;

  int fin_ids[$];
  int g0_cnt;

  function automatic longint add_model(input longint s, input longint v);
    longint full = 64'sd1 <<< DW;
`ifdef ACC_SCHED_SAT_EN
    longint half = 64'sd1 <<< (DW-1);
    longint ss   = (s >= half) ? s - full : s;
    longint vs   = (v >= half) ? v - full : v;
    longint t    = ss + vs;
    if (t > half - 1) t = half - 1;
    if (t < -half)    t = -half;
    return (t < 0) ? t + full : t;
`else
    return (s + v) % full;
`endif
  endfunction

  task automatic model_step(input logic [NREQ-1:0] r, input logic rs,
                            input logic [NREQ*DW-1:0] d);
    if (rs) begin
      m_pend = '0; m_last = NREQ-1; m_job = 0; m_pos = 0;
      m_active = 0; m_wrap = 0; m_sum = 0; m_out = '0; m_oid = 0; m_fin = 0;
      return;
    end
    m_fin = 0;
    if (!m_active) begin
      if (m_pend != 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (m_pend[c]) begin m_job = c; break; end
        end
        m_pend[m_job] = 1'b0;
        m_active = 1; m_wrap = 0; m_pos = 0; m_sum = 0;
      end
    end else if (!m_wrap) begin
      m_sum = add_model(m_sum, longint'(d[m_job*DW +: DW]));
      m_pos++;
      if (m_pos == LEN) m_wrap = 1;
    end else begin
      m_out = m_sum[DW-1:0]; m_oid = m_job; m_fin = 1; m_last = m_job;
      m_active = 0; m_wrap = 0;
    end
    m_pend |= r;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ*DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic tick(input logic [NREQ-1:0] r, input logic rs, input logic [NREQ*DW-1:0] d);
    logic [NREQ-1:0] eg;
    req = r; rst = rs; sdi = d;
    @(posedge clk);
    model_step(r, rs, d);
    #1;
    eg = (m_active && !m_wrap) ? NREQ'(1 << m_job) : '0;
    chk("grant",  64'(grant),  64'(eg));
    chk("busy",   64'(busy),   64'(m_active));
    chk("finish", 64'(finish), 64'(m_fin));
    chk("out",    64'(out),    64'(m_out));
    chk("out_id", 64'(out_id), 64'(m_oid));
    if (finish === 1'b1) fin_ids.push_back(int'(out_id));
    if (grant === 4'b0001) g0_cnt++;
    req = '0; rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((m_active || m_pend != 0) && n < maxc) begin
      tick('0, 1'b0, rnd());
      n++;
    end
    checks++;
    assert (n < maxc) else begin
      failures++;
      $error("FAIL drain_timeout got=%0d exp<%0d", n, maxc);
    end
  endtask

  task automatic do_reset();
    tick('0, 1'b1, rnd());
    tick('0, 1'b1, rnd());
    fin_ids = {};
  endtask

  task automatic solo_job(input logic [DW-1:0] v, input logic [DW-1:0] ev, input string tag);
    logic [NREQ*DW-1:0] d;
    int n = 0;
    fin_ids = {};
    d = rnd(); d[DW-1:0] = v;
    tick(4'b0001, 1'b0, d);
    while (fin_ids.size() == 0 && n < 30) begin
      d = rnd(); d[DW-1:0] = v;
      tick('0, 1'b0, d);
      n++;
    end
    chk({tag, "_seen"}, 64'(fin_ids.size()), 64'd1);
    chk(tag, 64'(out), 64'(ev));
  endtask

  initial begin
    logic [NREQ*DW-1:0] d;
    int n;

    // reset state
    do_reset();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_out",   64'(out),   64'd0);
    chk("rst_fin",   64'(finish), 64'd0);

    // lane0 = 1..7 -> 28, finish in cycle 10 after the pulse
    g0_cnt = 0;
    tick(4'b0001, 1'b0, rnd());
    tick('0, 1'b0, rnd());
    for (int k = 1; k <= LEN; k++) begin
      d = rnd(); d[DW-1:0] = DW'(k);
      tick('0, 1'b0, d);
    end
    tick('0, 1'b0, rnd());
    chk("seq_finish", 64'(finish), 64'd1);
    chk("seq_out",    64'(out),    64'd28);
    chk("seq_out_id", 64'(out_id), 64'd0);
    chk("seq_grants", 64'(g0_cnt), 64'd7);
    tick('0, 1'b0, rnd());
    chk("seq_fin_pulse", 64'(finish), 64'd0);
    chk("seq_out_hold",  64'(out),    64'd28);

    // all four at once from reset -> 0,1,2,3
    do_reset();
    tick(4'b1111, 1'b0, rnd());
    drain(100);
    chk("all4_n", 64'(fin_ids.size()), 64'd4);
    for (int i = 0; i < 4 && i < fin_ids.size(); i++)
      chk("all4_id", 64'(fin_ids[i]), 64'(i));

    // wrap-around or saturation
    do_reset();
`ifdef ACC_SCHED_SAT_EN
    solo_job(16'h7000, 16'h7FFF, "sat_pos");
    solo_job(16'h9000, 16'h8000, "sat_neg");
`else
    solo_job(16'hF000, 16'h9000, "wrap");
`endif

    // requester 2 re-requests during its own job
    do_reset();
    tick(4'b1101, 1'b0, rnd());
    n = 0;
    while (!(m_active && !m_wrap && m_job == 2) && n < 60) begin
      tick('0, 1'b0, rnd()); n++;
    end
    chk("r2_reached", 64'(n < 60), 64'd1);
    tick(4'b0100, 1'b0, rnd());
    drain(100);
    chk("r2_n", 64'(fin_ids.size()), 64'd4);
    if (fin_ids.size() == 4) begin
      chk("r2_id0", 64'(fin_ids[0]), 64'd0);
      chk("r2_id1", 64'(fin_ids[1]), 64'd2);
      chk("r2_id2", 64'(fin_ids[2]), 64'd3);
      chk("r2_id3", 64'(fin_ids[3]), 64'd2);
    end

    // reset in the 4th RUN cycle aborts the job
    do_reset();
    tick(4'b0001, 1'b0, rnd());
    n = 0;
    while (!(m_active && !m_wrap && m_pos == 3) && n < 20) begin
      tick('0, 1'b0, rnd()); n++;
    end
    chk("abort_reached", 64'(n < 20), 64'd1);
    tick(4'b1111, 1'b1, rnd());
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_busy",  64'(busy),  64'd0);
    chk("abort_out",   64'(out),   64'd0);
    chk("abort_id",    64'(out_id), 64'd0);
    for (int i = 0; i < 12; i++) tick('0, 1'b0, rnd());
    chk("abort_nofin", 64'(fin_ids.size()), 64'd0);
    chk("abort_idle",  64'(busy), 64'd0);
    tick(4'b0100, 1'b0, rnd());
    drain(40);
    chk("abort_fresh_n", 64'(fin_ids.size()), 64'd1);
    if (fin_ids.size() == 1) chk("abort_fresh_id", 64'(fin_ids[0]), 64'd2);

    // after serving 0, pending {0,3} -> 3 first
    do_reset();
    tick(4'b0001, 1'b0, rnd());
    drain(40);
    fin_ids = {};
    tick(4'b1001, 1'b0, rnd());
    drain(60);
    chk("rr_n", 64'(fin_ids.size()), 64'd2);
    if (fin_ids.size() == 2) begin
      chk("rr_first",  64'(fin_ids[0]), 64'd3);
      chk("rr_second", 64'(fin_ids[1]), 64'd0);
    end

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [NREQ-1:0] r;
      r = ($urandom_range(0, 5) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
      tick(r, ($urandom_range(0, 199) == 0), rnd());
    end
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
